// File: rtl/eb_io_pkg.sv
// ============================================================================
// Module   : eb_io_pkg
// Brief    : Shared state encoding and defaults for the input debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eb_io_pkg;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_WHI = 2'd1,
        S_HI  = 2'd2,
        S_WLO = 2'd3
    } deb_state_t;

    // 1 ms of stability at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 50000;

endpackage : eb_io_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module   : debounce_channel
// Brief    : One input path: synchroniser, debounce FSM with stability counter,
//            and optional registered edge pulses (macro EDGE_PULSE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import eb_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    deb_state_t             r_state;
    deb_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_deb;
    logic                   w_deb_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LO;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_deb   <= w_deb_nxt;
        end
    end

    // The exit test uses the pre-increment count, so a WAIT state lasts
    // exactly DEBOUNCE_CYCLES cycles and the counter can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_LO: begin
                if (w_s) begin
                    w_state_nxt = S_WHI;
                    w_cnt_nxt   = '0;
                end
            end
            S_WHI: begin
                if (!w_s) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_ONE;
                end
            end
            S_HI: begin
                if (!w_s) begin
                    w_state_nxt = S_WLO;
                    w_cnt_nxt   = '0;
                end
            end
            S_WLO: begin
                if (w_s) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Decode the next state so the level changes on the same edge as the state
    assign w_deb_nxt = (w_state_nxt == S_HI) || (w_state_nxt == S_WLO);
    assign o_deb     = r_deb;

`ifdef EDGE_PULSE_EN
    logic r_deb_q;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_q <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_deb_q <= r_deb;
            r_rise  <= r_deb & ~r_deb_q;
            r_fall  <= ~r_deb & r_deb_q;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule : debounce_channel

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// Module   : input_debouncer
// Brief    : Two independent synchronise-and-debounce channels feeding the
//            AND-gate inputs; edge pulses built only with EDGE_PULSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
    import eb_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a_deb,
    output logic b_deb,
    output logic a_rise,
    output logic b_rise,
    output logic a_fall,
    output logic b_fall
);

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_a (
        .clk    (clk_50M),
        .rst    (reset),
        .i_raw  (raw_a),
        .o_deb  (a_deb),
        .o_rise (a_rise),
        .o_fall (a_fall)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_b (
        .clk    (clk_50M),
        .rst    (reset),
        .i_raw  (raw_b),
        .o_deb  (b_deb),
        .o_rise (b_rise),
        .o_fall (b_fall)
    );

endmodule : input_debouncer

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// Module   : tb_input_debouncer
// Brief    : Directed self-checking bench, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;
    import eb_io_pkg::*;

`ifdef EDGE_PULSE_EN
    localparam logic c_PULSE = 1'b1;
`else
    localparam logic c_PULSE = 1'b0;
`endif

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;
    logic raw_a   = 1'b0;
    logic raw_b   = 1'b0;
    logic a_deb, b_deb, a_rise, b_rise, a_fall, b_fall;

    int n_checks = 0;
    int n_errors = 0;

    input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4)
    ) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .a_deb   (a_deb),
        .b_deb   (b_deb),
        .a_rise  (a_rise),
        .b_rise  (b_rise),
        .a_fall  (a_fall),
        .b_fall  (b_fall)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_quiet(input string tag, input logic exp_deb);
        check({tag, " a_deb"}, 16'(a_deb), 16'(exp_deb));
        check({tag, " a_pulses"}, 16'({a_rise, a_fall}), 16'd0);
    endtask

    task automatic do_reset(input logic ra, input logic rb);
        reset = 1'b1;
        raw_a = ra;
        raw_b = rb;
        tick();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Case 1: inputs high through reset must fully re-qualify
        do_reset(1'b1, 1'b1);
        check("rst outputs", 16'({a_deb, b_deb, a_rise, b_rise, a_fall, b_fall}), 16'd0);
        check("rst state_a", 16'(dut.u_ch_a.r_state), 16'(S_LO));
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("c1 deb low", 16'({a_deb, b_deb}), 16'b00);
        end
        tick();
        check("c1 deb e7", 16'({a_deb, b_deb}), 16'b11);
        check("c1 rise e7", 16'({a_rise, b_rise}), 16'b00);
        tick();
        check("c1 rise e8", 16'({a_rise, b_rise}), {14'd0, c_PULSE, c_PULSE});
        check("c1 fall e8", 16'({a_fall, b_fall}), 16'b00);
        tick();
        check("c1 rise e9", 16'({a_rise, b_rise}), 16'b00);

        // Case 2: 3-cycle pulse on A is rejected
        do_reset(1'b0, 1'b0);
        tick();
        tick();
        raw_a = 1'b1;
        tick();
        tick();
        tick();
        check("c2 state e3", 16'(dut.u_ch_a.r_state), 16'(S_WHI));
        check("c2 cnt e3", 16'(dut.u_ch_a.r_cnt), 16'd0);
        raw_a = 1'b0;
        tick();
        tick();
        check("c2 cnt e5", 16'(dut.u_ch_a.r_cnt), 16'd2);
        tick();
        check("c2 state e6", 16'(dut.u_ch_a.r_state), 16'(S_LO));
        for (int e = 7; e <= 12; e++) begin
            tick();
            check_a_quiet("c2", 1'b0);
        end

        // Case 3 (and 6 when built without pulses): clean rise then fall on A
        raw_a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_a_quiet("c3 up", 1'b0);
        end
        tick();
        check_a_quiet("c3 up e7", 1'b1);
        tick();
        check("c3 a_rise e8", 16'(a_rise), 16'(c_PULSE));
        check("c3 a_deb e8", 16'(a_deb), 16'd1);
        tick();
        check_a_quiet("c3 up e9", 1'b1);
        raw_a = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_a_quiet("c3 dn", 1'b1);
        end
        tick();
        check_a_quiet("c3 dn e7", 1'b0);
        tick();
        check("c3 a_fall e8", 16'(a_fall), 16'(c_PULSE));
        check("c3 a_rise e8 dn", 16'(a_rise), 16'd0);
        tick();
        check_a_quiet("c3 dn e9", 1'b0);

        // Case 4: same-edge change, A held 5 cycles, B held 2
        raw_a = 1'b1;
        raw_b = 1'b1;
        tick();
        tick();
        raw_b = 1'b0;
        for (int e = 3; e <= 5; e++) begin
            tick();
            check("c4 deb early", 16'({a_deb, b_deb}), 16'b00);
        end
        raw_a = 1'b0;
        tick();
        check("c4 deb e6", 16'({a_deb, b_deb}), 16'b00);
        tick();
        check("c4 deb e7", 16'({a_deb, b_deb}), 16'b10);
        for (int e = 8; e <= 11; e++) begin
            tick();
            check("c4 deb hold", 16'({a_deb, b_deb}), 16'b10);
            check("c4 b pulses", 16'({b_rise, b_fall}), 16'b00);
        end
        tick();
        check("c4 deb e12", 16'({a_deb, b_deb}), 16'b00);
        check("c4 state_b", 16'(dut.u_ch_b.r_state), 16'(S_LO));

        // Case 5: reset mid-debounce aborts, then full re-qualification
        tick();
        tick();
        raw_a = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        check("c5 state pre", 16'(dut.u_ch_a.r_state), 16'(S_WHI));
        check("c5 cnt pre", 16'(dut.u_ch_a.r_cnt), 16'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("c5 state rst", 16'(dut.u_ch_a.r_state), 16'(S_LO));
        check("c5 cnt rst", 16'(dut.u_ch_a.r_cnt), 16'd0);
        check("c5 deb rst", 16'(a_deb), 16'd0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_a_quiet("c5 requal", 1'b0);
        end
        tick();
        check("c5 deb e7", 16'(a_deb), 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_input_debouncer

`default_nettype wire
